// File: rtl/fir_sched_if.sv
// Stream, BRAM and MAC-control bundle between fir_sched (master) and its
// surroundings (slave: input stream source, BRAM11 pair, MAC datapath, sink).
interface fir_sched_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic                   ss_tvalid;
  logic [pDATA_WIDTH-1:0] ss_tdata;
  logic                   ss_tlast;
  logic                   ss_tready;
  logic [3:0]             data_WE;
  logic                   data_EN;
  logic [pADDR_WIDTH-1:0] data_A;
  logic [pDATA_WIDTH-1:0] data_Di;
  logic                   tap_EN;
  logic [pADDR_WIDTH-1:0] tap_A;
  logic                   mac_clr;
  logic                   mac_en;
  logic                   y_valid;
  logic                   y_ready;
  logic                   y_last;

  modport master (
    input  ss_tvalid, ss_tdata, ss_tlast, y_ready,
    output ss_tready, data_WE, data_EN, data_A, data_Di, tap_EN, tap_A,
           mac_clr, mac_en, y_valid, y_last
  );
  modport slave (
    output ss_tvalid, ss_tdata, ss_tlast, y_ready,
    input  ss_tready, data_WE, data_EN, data_A, data_Di, tap_EN, tap_A,
           mac_clr, mac_en, y_valid, y_last
  );
endinterface

// File: rtl/fir_sched.sv
// Sequencer for the 11-tap FIR: ap_start/ap_done/ap_idle, circular data buffer,
// tap/data RAM addressing and MAC pacing. Optional: FIR_SCHED_TLAST_CHECK_EN.
module fir_sched #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic        axis_clk,
  input  logic        axis_rst,
  input  logic        ap_start,
  input  logic [31:0] data_length,
  input  logic        done_clr,
  output logic        ap_idle,
  output logic        ap_done,
  output logic        tap_busy,
  output logic        tlast_err,
  fir_sched_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WAIT_IN, S_MAC, S_DRAIN, S_OUT, S_DONE
  } state_t;

  localparam logic [3:0] KLAST = 4'(Tape_Num - 1);

  state_t      state, nxt_state;
  logic [3:0]  k, wp;
  logic [31:0] cnt, len;
  logic        done_r, mac_vld, mac_first;
  logic        last_cnt, fin, last_smp;
  logic [4:0]  didx;

  assign last_cnt = (cnt == len - 32'd1);
  assign last_smp = last_cnt | fin;

  // Circular read index: newest sample at k=0, walking back in time.
  always_comb begin
    if (wp >= k) didx = {1'b0, wp - k};
    else         didx = 5'(wp) + 5'(Tape_Num) - 5'(k);
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) state <= S_IDLE;
    else          state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      S_IDLE:    if (ap_start) nxt_state = S_INIT;
      S_INIT:    if (k == KLAST) nxt_state = (len == 32'd0) ? S_DONE : S_WAIT_IN;
      S_WAIT_IN: if (bus.ss_tvalid) nxt_state = S_MAC;
      S_MAC:     if (k == KLAST) nxt_state = S_DRAIN;
      S_DRAIN:   nxt_state = S_OUT;
      S_OUT:     if (bus.y_ready) nxt_state = last_smp ? S_DONE : S_WAIT_IN;
      S_DONE:    nxt_state = S_IDLE;
      default:   nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      k         <= '0;
      wp        <= '0;
      cnt       <= '0;
      len       <= '0;
      done_r    <= 1'b0;
      mac_vld   <= 1'b0;
      mac_first <= 1'b0;
    end else begin
      // RAM read data lands one cycle after the address, so MAC trails by one.
      mac_vld   <= (state == S_MAC);
      mac_first <= (state == S_MAC) && (k == '0);
      if (state == S_DONE) done_r <= 1'b1;
      else if (done_clr)   done_r <= 1'b0;
      case (state)
        S_IDLE: if (ap_start) begin
          len    <= data_length;
          wp     <= '0;
          cnt    <= '0;
          k      <= '0;
          done_r <= 1'b0;
        end
        S_INIT, S_MAC: k <= (k == KLAST) ? 4'd0 : k + 4'd1;
        S_OUT: if (bus.y_ready) begin
          wp  <= (wp == KLAST) ? 4'd0 : wp + 4'd1;
          cnt <= cnt + 32'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef FIR_SCHED_TLAST_CHECK_EN
  logic fin_r, err_r;
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      fin_r <= 1'b0;
      err_r <= 1'b0;
    end else if (state == S_IDLE && ap_start) begin
      fin_r <= 1'b0;
      err_r <= 1'b0;
    end else if (state == S_WAIT_IN && bus.ss_tvalid) begin
      if (bus.ss_tlast && !last_cnt) begin
        fin_r <= 1'b1;
        err_r <= 1'b1;
      end else if (!bus.ss_tlast && last_cnt) begin
        err_r <= 1'b1;
      end
    end
  end
  assign fin       = fin_r;
  assign tlast_err = err_r;
`else
  logic unused_tlast;
  assign unused_tlast = bus.ss_tlast;
  assign fin          = 1'b0;
  assign tlast_err    = 1'b0;
`endif

  always_comb begin
    ap_idle       = (state == S_IDLE) || (state == S_DONE);
    tap_busy      = !ap_idle;
    ap_done       = done_r || (state == S_DONE);
    bus.ss_tready = 1'b0;
    bus.data_WE   = 4'h0;
    bus.data_EN   = 1'b0;
    bus.data_A    = '0;
    bus.data_Di   = {pDATA_WIDTH{1'b0}};
    bus.tap_EN    = 1'b0;
    bus.tap_A     = '0;
    bus.mac_en    = mac_vld;
    bus.mac_clr   = mac_first;
    bus.y_valid   = 1'b0;
    bus.y_last    = 1'b0;
    case (state)
      S_INIT: begin
        bus.data_EN = 1'b1;
        bus.data_WE = 4'hF;
        bus.data_A  = pADDR_WIDTH'({k, 2'b00});
      end
      S_WAIT_IN: begin
        bus.ss_tready = 1'b1;
        if (bus.ss_tvalid) begin
          bus.data_EN = 1'b1;
          bus.data_WE = 4'hF;
          bus.data_A  = pADDR_WIDTH'({wp, 2'b00});
          bus.data_Di = bus.ss_tdata;
        end
      end
      S_MAC: begin
        bus.data_EN = 1'b1;
        bus.tap_EN  = 1'b1;
        bus.data_A  = pADDR_WIDTH'({didx, 2'b00});
        bus.tap_A   = pADDR_WIDTH'({k, 2'b00});
      end
      S_OUT: begin
        bus.y_valid = 1'b1;
        bus.y_last  = last_smp;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_fir_sched.sv
// Bench for fir_sched: BRAM/MAC environment model, queued stream source,
// scoreboard of hand-computed FIR outputs, and cycle-exact directed checks.
module tb_fir_sched;
  logic        axis_clk = 1'b0;
  logic        axis_rst = 1'b1;
  logic        ap_start = 1'b0;
  logic [31:0] data_length = '0;
  logic        done_clr = 1'b0;
  logic        ap_idle, ap_done, tap_busy, tlast_err;

  fir_sched_if bus ();

  fir_sched dut (
    .axis_clk    (axis_clk),
    .axis_rst    (axis_rst),
    .ap_start    (ap_start),
    .data_length (data_length),
    .done_clr    (done_clr),
    .ap_idle     (ap_idle),
    .ap_done     (ap_done),
    .tap_busy    (tap_busy),
    .tlast_err   (tlast_err),
    .bus         (bus)
  );

  always #5 axis_clk = ~axis_clk;

  typedef struct { logic [31:0] d; logic l; } smp_t;
  typedef struct { logic [31:0] y; logic last; } exp_t;
  smp_t src_q[$];
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_out   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Environment: taps h[k]=k+1, data RAM preloaded with junk INIT must clear.
  logic [31:0] dmem [0:10];
  logic [31:0] tmem [0:10];
  logic [31:0] data_q, tap_q, acc;
  initial begin
    for (int i = 0; i < 11; i++) begin
      tmem[i] = 32'(i + 1);
      dmem[i] <= 32'h100 + 32'(i);
    end
    data_q <= '0;
    tap_q  <= '0;
    acc    <= '0;
  end
  always @(posedge axis_clk) begin
    if (bus.data_EN) begin
      if (bus.data_WE == 4'hF) dmem[bus.data_A[5:2]] <= bus.data_Di;
      data_q <= dmem[bus.data_A[5:2]];
    end
    if (bus.tap_EN) tap_q <= tmem[bus.tap_A[5:2]];
    if (bus.mac_en) acc <= (bus.mac_clr ? 32'd0 : acc) + tap_q * data_q;
  end

  // Stream source: presents the head of src_q, pops after each accept.
  initial begin
    logic fire;
    bus.ss_tvalid = 1'b0;
    bus.ss_tdata  = '0;
    bus.ss_tlast  = 1'b0;
    forever begin
      @(negedge axis_clk);
      fire = bus.ss_tvalid && bus.ss_tready && !axis_rst;
      @(posedge axis_clk);
      #1;
      if (fire && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0) begin
        bus.ss_tvalid = 1'b1;
        bus.ss_tdata  = src_q[0].d;
        bus.ss_tlast  = src_q[0].l;
      end else begin
        bus.ss_tvalid = 1'b0;
        bus.ss_tdata  = '0;
        bus.ss_tlast  = 1'b0;
      end
    end
  end

  // Output monitor / scoreboard.
  always @(negedge axis_clk) begin
    if (!axis_rst && bus.y_valid && bus.y_ready) begin
      if (exp_q.size() == 0) chk("y_unexpected", bus.y_valid, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("y_data", acc, e.y);
        chk("y_last", bus.y_last, e.last);
        chk("tready_with_yvalid", bus.ss_tready, 0);
      end
      n_out++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic nxt();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic start(input logic [31:0] n);
    data_length = n;
    ap_start    = 1'b1;
    nxt();
    ap_start    = 1'b0;
  endtask

  task automatic push_src(input logic [31:0] d, input logic l);
    smp_t s;
    s.d = d; s.l = l;
    src_q.push_back(s);
  endtask

  task automatic push_exp(input logic [31:0] y, input logic last);
    exp_t e;
    e.y = y; e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string nm, input int max);
    for (int i = 0; i < max && !ap_done; i++) nxt();
    chk(nm, ap_done, 1);
  endtask

  initial begin
    int exp_da[11] = '{4, 0, 40, 36, 32, 28, 24, 20, 16, 12, 8};
    int init_bad, t_rdy, done_c, mac_bad, clr_c, clr_n, en_n, bp_bad, tr_seen;
    int yv[$];
    bus.y_ready = 1'b1;

    // Reset state
    repeat (3) nxt();
    axis_rst = 1'b0;
    chk("rst_idle", ap_idle, 1);
    chk("rst_done", ap_done, 0);
    chk("rst_busy", tap_busy, 0);
    chk("rst_outs", {bus.data_EN, bus.tap_EN, bus.mac_en, bus.mac_clr,
                     bus.y_valid, bus.y_last, bus.ss_tready, bus.data_WE}, 0);
    chk("rst_err", tlast_err, 0);

    // Run 1: length 3, samples 1,2,3 -> y = 1, 4, 10
    push_src(1, 0); push_src(2, 0); push_src(3, 1);
    push_exp(1, 0); push_exp(4, 0); push_exp(10, 1);
    init_bad = 0; t_rdy = -1; done_c = -1; mac_bad = 0; clr_c = -1; clr_n = 0; en_n = 0;
    start(3);
    for (int c = 1; c <= 60; c++) begin
      if (c <= 11 && !(bus.data_EN && bus.data_WE == 4'hF && bus.data_A == 12'(4 * (c - 1))
                       && bus.data_Di == 0 && !bus.ss_tready && tap_busy)) init_bad++;
      if (bus.ss_tready && t_rdy < 0) t_rdy = c;
      if (bus.y_valid) yv.push_back(c);
      if (c >= 27 && c <= 37 && !(bus.data_A == 12'(exp_da[c - 27]) && bus.tap_A == 12'(4 * (c - 27))
                                  && bus.tap_EN && bus.data_EN && bus.data_WE == 4'h0)) mac_bad++;
      if (c >= 27 && c <= 39 && bus.mac_clr) begin
        clr_n++;
        if (clr_c < 0) clr_c = c;
      end
      if (c >= 27 && c <= 39 && bus.mac_en) en_n++;
      if (ap_done && done_c < 0) done_c = c;
      if (c == 54) chk("done_idle", ap_idle, 1);
      if (c == 56) chk("done_clr_priority", ap_done, 1);
      if (c == 59) chk("done_clr", ap_done, 0);
      ap_start = (c == 30);
      done_clr = (c == 54) || (c == 57);
      nxt();
    end
    ap_start = 1'b0;
    done_clr = 1'b0;
    chk("init_clear", init_bad, 0);
    chk("first_tready", t_rdy, 12);
    chk("yv_count", yv.size(), 3);
    if (yv.size() == 3) begin
      chk("yv_cycle0", yv[0], 25);
      chk("yv_cycle1", yv[1], 39);
      chk("yv_cycle2", yv[2], 53);
    end
    chk("mac_addr_wp1", mac_bad, 0);
    chk("mac_clr_cycle", clr_c, 28);
    chk("mac_clr_count", clr_n, 1);
    chk("mac_en_count", en_n, 11);
    chk("done_cycle", done_c, 54);
    chk("no_tlast_err", tlast_err, 0);

    // Run 2: backpressure, samples 5,7 -> y = 5, 17
    push_src(5, 0); push_src(7, 1);
    push_exp(5, 0); push_exp(17, 1);
    bus.y_ready = 1'b0;
    start(2);
    for (int i = 0; i < 40 && !bus.y_valid; i++) nxt();
    chk("bp_yvalid", bus.y_valid, 1);
    bp_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (!(bus.y_valid && !bus.ss_tready && !bus.tap_EN && !bus.data_EN && !bus.mac_en)) bp_bad++;
      nxt();
    end
    chk("bp_hold", bp_bad, 0);
    bus.y_ready = 1'b1;
    wait_done("bp_done", 60);
    repeat (3) nxt();

    // Run 3: length 0
    start(0);
    tr_seen = 0; done_c = -1;
    for (int c = 1; c <= 14; c++) begin
      if (bus.ss_tready) tr_seen++;
      if (ap_done && done_c < 0) done_c = c;
      nxt();
    end
    chk("len0_done_cycle", done_c, 12);
    chk("len0_no_tready", tr_seen, 0);

    // Run 4: reset at MAC k=5, then restart length 2 with 2,3 -> y = 2, 7
    push_src(9, 0);
    start(3);
    repeat (17) nxt();
    chk("mid_mac_k5", bus.tap_A, 20);
    axis_rst = 1'b1;
    nxt();
    chk("midrst_idle", ap_idle, 1);
    chk("midrst_outs", {bus.data_EN, bus.tap_EN, bus.mac_en, bus.mac_clr,
                        bus.y_valid, bus.ss_tready, bus.data_WE}, 0);
    axis_rst = 1'b0;
    nxt();
    push_src(2, 0); push_src(3, 1);
    push_exp(2, 0); push_exp(7, 1);
    start(2);
    wait_done("restart_done", 60);
    repeat (3) nxt();

    // Run 5: length 600, tlast on sample index 4; ones in -> y = 1,3,6,10,15
    n_out = 0;
    for (int i = 0; i < 5; i++) push_src(1, i == 4);
`ifdef FIR_SCHED_TLAST_CHECK_EN
    push_exp(1, 0); push_exp(3, 0); push_exp(6, 0); push_exp(10, 0); push_exp(15, 1);
    start(600);
    wait_done("tlast_done", 120);
    chk("tlast_outputs", n_out, 5);
    chk("tlast_err_set", tlast_err, 1);
`else
    push_exp(1, 0); push_exp(3, 0); push_exp(6, 0); push_exp(10, 0); push_exp(15, 0);
    start(600);
    for (int i = 0; i < 120 && n_out < 5; i++) nxt();
    repeat (3) nxt();
    chk("tlast_outputs", n_out, 5);
    chk("tlast_err_off", tlast_err, 0);
    chk("tlast_still_busy", tap_busy, 1);
    axis_rst = 1'b1;
    nxt();
    axis_rst = 1'b0;
`endif
    nxt();
    chk("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
